// File: rtl/player_pkg.sv
// Shared types and constants for the maze player controller.
// Teleport pairs are only reachable when PLAYER_CTRL_TP_EN is defined.
package player_pkg;

  localparam int GRID_COLS = 20;
  localparam int GRID_ROWS = 16;

  localparam logic [4:0] START_COL = 5'd0;
  localparam logic [3:0] START_ROW = 4'd0;
  localparam logic [4:0] COL_MAX   = 5'(GRID_COLS - 1);
  localparam logic [3:0] ROW_MAX   = 4'(GRID_ROWS - 1);

  typedef enum logic [2:0] {
    S_PLAY  = 3'd0,
    S_CHECK = 3'd1,
    S_DEAD  = 3'd2,
    S_WIN   = 3'd3
`ifdef PLAYER_CTRL_TP_EN
    , S_TP  = 3'd4
`endif
  } state_t;

  typedef struct packed {
    logic [4:0] col;
    logic [3:0] row;
  } cell_t;

  typedef struct packed {
    logic  hit;
    cell_t dst;
  } tp_res_t;

  localparam cell_t TP_A0 = '{col: 5'd7,  row: 4'd5};
  localparam cell_t TP_A1 = '{col: 5'd13, row: 4'd3};
  localparam cell_t TP_B0 = '{col: 5'd0,  row: 4'd15};
  localparam cell_t TP_B1 = '{col: 5'd9,  row: 4'd8};

  // Pairs are symmetric: either end jumps to the other.
  function automatic tp_res_t tp_lookup(input cell_t src);
    tp_res_t r;
    r.hit = 1'b1;
    r.dst = src;
    case (src)
      TP_A0:   r.dst = TP_A1;
      TP_A1:   r.dst = TP_A0;
      TP_B0:   r.dst = TP_B1;
      TP_B1:   r.dst = TP_B0;
      default: r.hit = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Registered rising-edge detector for the debounced key levels.
module btn_edge #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] level,
  output logic [W-1:0] rise
);

  logic [W-1:0] prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      prev <= '0;
      rise <= '0;
    end else begin
      prev <= level;
      rise <= level & ~prev;
    end
  end

endmodule

// File: rtl/player_ctrl.sv
// Player position controller: key presses to cell moves, box output, death/teleport/win.
// Teleport behaviour is compiled in only when PLAYER_CTRL_TP_EN is defined.
//
//   state   | meaning
//   S_PLAY  | waiting for a key press
//   S_CHECK | box shows new cell, classifier flags evaluated
//   S_TP    | jump to the paired teleport cell
//   S_DEAD  | death timer running, respawn at terminal count
//   S_WIN   | goal reached, hold until restart
module player_ctrl
  import player_pkg::*;
#(
  parameter int CELL_W      = 32,
  parameter int CELL_H      = 30,
  parameter int BOX         = 16,
  parameter int DEAD_CYCLES = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] btn,
  input  logic [3:0] wall,
  input  logic       restart,
  input  logic       startblk,
  input  logic       tpblks,
  input  logic       lavablks,
  input  logic       goalblk,
  output logic [9:0] xFlr,
  output logic [9:0] xCeil,
  output logic [9:0] yFlr,
  output logic [9:0] yCeil,
  output logic       dead,
  output logic       won,
  output logic [7:0] deaths
);

  localparam int CW    = $clog2(DEAD_CYCLES + 1);
  localparam int X_OFF = (CELL_W - BOX) / 2;
  localparam int Y_OFF = (CELL_H - BOX) / 2;

  function automatic logic [9:0] x_floor(input logic [4:0] c);
    return 10'(10'(c) * 10'(CELL_W) + 10'(X_OFF));
  endfunction

  function automatic logic [9:0] y_floor(input logic [3:0] r);
    return 10'(10'(r) * 10'(CELL_H) + 10'(Y_OFF));
  endfunction

  state_t        state, state_nxt;
  logic [4:0]    col, col_nxt;
  logic [3:0]    row, row_nxt;
  logic [7:0]    deaths_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [3:0]    press;

  // startblk carries no consequence here; the respawn cell is fixed.
  logic unused_flags;
  assign unused_flags = startblk;

`ifdef PLAYER_CTRL_TP_EN
  logic    tp_armed, tp_armed_nxt;
  tp_res_t tp_res;
  assign tp_res = tp_lookup('{col: col, row: row});
`else
  logic unused_tp;
  assign unused_tp = tpblks;
`endif

  btn_edge #(.W(4)) u_btn_edge (
    .clk   (clk),
    .reset (reset),
    .level (btn),
    .rise  (press)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_PLAY;
      col    <= START_COL;
      row    <= START_ROW;
      deaths <= '0;
      cnt    <= '0;
      xFlr   <= x_floor(START_COL);
      xCeil  <= 10'(x_floor(START_COL) + 10'(BOX));
      yFlr   <= y_floor(START_ROW);
      yCeil  <= 10'(y_floor(START_ROW) + 10'(BOX));
`ifdef PLAYER_CTRL_TP_EN
      tp_armed <= 1'b1;
`endif
    end else begin
      state  <= state_nxt;
      col    <= col_nxt;
      row    <= row_nxt;
      deaths <= deaths_nxt;
      cnt    <= cnt_nxt;
      // Box follows the next-cell value so it lands together with col/row.
      xFlr   <= x_floor(col_nxt);
      xCeil  <= 10'(x_floor(col_nxt) + 10'(BOX));
      yFlr   <= y_floor(row_nxt);
      yCeil  <= 10'(y_floor(row_nxt) + 10'(BOX));
`ifdef PLAYER_CTRL_TP_EN
      tp_armed <= tp_armed_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt  = state;
    col_nxt    = col;
    row_nxt    = row;
    deaths_nxt = deaths;
    cnt_nxt    = cnt;
`ifdef PLAYER_CTRL_TP_EN
    tp_armed_nxt = tp_armed;
`endif
    if (restart) begin
      state_nxt  = S_PLAY;
      col_nxt    = START_COL;
      row_nxt    = START_ROW;
      deaths_nxt = '0;
      cnt_nxt    = '0;
`ifdef PLAYER_CTRL_TP_EN
      tp_armed_nxt = 1'b1;
`endif
    end else begin
      case (state)
        S_PLAY: begin
          // The highest-priority press wins even if it is blocked.
          if (press[3]) begin
            if (!wall[3] && row != '0) begin
              row_nxt   = row - 4'd1;
              state_nxt = S_CHECK;
            end
          end else if (press[2]) begin
            if (!wall[2] && row != ROW_MAX) begin
              row_nxt   = row + 4'd1;
              state_nxt = S_CHECK;
            end
          end else if (press[1]) begin
            if (!wall[1] && col != '0) begin
              col_nxt   = col - 5'd1;
              state_nxt = S_CHECK;
            end
          end else if (press[0]) begin
            if (!wall[0] && col != COL_MAX) begin
              col_nxt   = col + 5'd1;
              state_nxt = S_CHECK;
            end
          end
        end
        S_CHECK: begin
`ifdef PLAYER_CTRL_TP_EN
          if (!tpblks) tp_armed_nxt = 1'b1;
`endif
          if (goalblk) begin
            state_nxt = S_WIN;
          end else if (lavablks) begin
            state_nxt = S_DEAD;
            cnt_nxt   = CW'(DEAD_CYCLES - 1);
            if (deaths != 8'hFF) deaths_nxt = deaths + 8'd1;
`ifdef PLAYER_CTRL_TP_EN
          end else if (tpblks && tp_armed) begin
            state_nxt = S_TP;
`endif
          end else begin
            state_nxt = S_PLAY;
          end
        end
`ifdef PLAYER_CTRL_TP_EN
        S_TP: begin
          if (tp_res.hit) begin
            col_nxt = tp_res.dst.col;
            row_nxt = tp_res.dst.row;
          end
          tp_armed_nxt = 1'b0;
          state_nxt    = S_PLAY;
        end
`endif
        S_DEAD: begin
          if (cnt == '0) begin
            col_nxt   = START_COL;
            row_nxt   = START_ROW;
            state_nxt = S_PLAY;
          end else begin
            cnt_nxt = cnt - CW'(1);
          end
        end
        S_WIN:   state_nxt = S_WIN;
        default: state_nxt = S_PLAY;
      endcase
    end
  end

  assign dead = (state == S_DEAD);
  assign won  = (state == S_WIN);

endmodule

// File: tb/tb_player_ctrl.sv
// Directed bench for player_ctrl with a short death timer; follows PLAYER_CTRL_TP_EN.
module tb_player_ctrl;

  localparam logic [3:0] UP    = 4'b1000;
  localparam logic [3:0] DOWN  = 4'b0100;
  localparam logic [3:0] LEFT  = 4'b0010;
  localparam logic [3:0] RIGHT = 4'b0001;

  logic       clk = 1'b0;
  logic       reset, restart;
  logic [3:0] btn, wall;
  logic       startblk, tpblks, lavablks, goalblk;
  logic [9:0] xFlr, xCeil, yFlr, yCeil;
  logic       dead, won;
  logic [7:0] deaths;

  int n_checks = 0;
  int n_errors = 0;
  int dead_len;

  always #5 clk = ~clk;

  player_ctrl #(.CELL_W(32), .CELL_H(30), .BOX(16), .DEAD_CYCLES(5)) dut (
    .clk(clk), .reset(reset), .btn(btn), .wall(wall), .restart(restart),
    .startblk(startblk), .tpblks(tpblks), .lavablks(lavablks), .goalblk(goalblk),
    .xFlr(xFlr), .xCeil(xCeil), .yFlr(yFlr), .yCeil(yCeil),
    .dead(dead), .won(won), .deaths(deaths)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Press edge, then the S_CHECK cycle with the given flags, then the decision edge.
  task automatic move(input logic [3:0] b, input logic [3:0] w,
                      input logic lava, input logic goal, input logic tp);
    btn = b; wall = w;
    tick();
    btn = 4'b0;
    tick();
    lavablks = lava; goalblk = goal; tpblks = tp;
    tick();
    lavablks = 1'b0; goalblk = 1'b0; tpblks = 1'b0; wall = 4'b0;
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    tick();
    restart = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; restart = 1'b0; btn = '0; wall = '0;
    startblk = 1'b0; tpblks = 1'b0; lavablks = 1'b0; goalblk = 1'b0;
    repeat (2) tick();
    reset = 1'b0;

    check("rst_xflr", xFlr, 8);
    check("rst_xceil", xCeil, 24);
    check("rst_yflr", yFlr, 7);
    check("rst_yceil", yCeil, 23);
    check("rst_dead", dead, 0);
    check("rst_won", won, 0);
    check("rst_deaths", deaths, 0);

    // first right press: box moves after two edges
    btn = RIGHT;
    tick();
    btn = 4'b0;
    check("r1_before", xFlr, 8);
    tick();
    check("r1_xflr", xFlr, 40);
    check("r1_xceil", xCeil, 56);
    check("r1_yflr", yFlr, 7);
    tick();
    check("r1_dead", dead, 0);
    check("r1_won", won, 0);

    // blocked moves: lava asserted on the would-be check cycle must not kill
    move(UP, 4'b0, 1'b1, 1'b0, 1'b0);
    check("up_edge_x", xFlr, 40);
    check("up_edge_y", yFlr, 7);
    check("up_edge_dead", dead, 0);
    move(LEFT, 4'b0, 1'b0, 1'b0, 1'b0);
    check("left_x", xFlr, 8);
    move(LEFT, 4'b0, 1'b1, 1'b0, 1'b0);
    check("left_edge_x", xFlr, 8);
    check("left_edge_dead", dead, 0);
    move(DOWN, 4'b0, 1'b0, 1'b0, 1'b0);
    check("down_y", yFlr, 37);
    check("down_yceil", yCeil, 53);
    move(UP, 4'b1000, 1'b1, 1'b0, 1'b0);
    check("up_wall_y", yFlr, 37);
    check("up_wall_dead", dead, 0);

    // simultaneous up+right from (0,1): only up applies
    move(UP | RIGHT, 4'b0, 1'b0, 1'b0, 1'b0);
    check("prio_x", xFlr, 8);
    check("prio_y", yFlr, 7);

    // death on (1,0), timer of 5 cycles, respawn at start
    move(RIGHT, 4'b0, 1'b1, 1'b0, 1'b0);
    check("death_dead", dead, 1);
    check("death_cnt", deaths, 1);
    check("death_x_during", xFlr, 40);
    dead_len = 0;
    for (int k = 0; k < 20; k++) begin
      if (!dead) break;
      dead_len++;
      tick();
    end
    check("death_len", dead_len, 5);
    check("respawn_xflr", xFlr, 8);
    check("respawn_xceil", xCeil, 24);
    check("respawn_yflr", yFlr, 7);
    check("respawn_yceil", yCeil, 23);

    // goal beats lava; win holds against presses until restart
    move(RIGHT, 4'b0, 1'b1, 1'b1, 1'b0);
    check("win_won", won, 1);
    check("win_dead", dead, 0);
    check("win_deaths", deaths, 1);
    check("win_x", xFlr, 40);
    move(LEFT, 4'b0, 1'b0, 1'b0, 1'b0);
    check("win_hold_x", xFlr, 40);
    check("win_hold_won", won, 1);
    pulse_restart();
    check("rs_won", won, 0);
    check("rs_x", xFlr, 8);
    check("rs_y", yFlr, 7);
    check("rs_deaths", deaths, 0);

    // walk to (6,5), then step onto teleport cell (7,5)
    for (int i = 0; i < 6; i++) move(RIGHT, 4'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) move(DOWN, 4'b0, 1'b0, 1'b0, 1'b0);
    check("walk_x", xFlr, 200);
    check("walk_y", yFlr, 157);
    move(RIGHT, 4'b0, 1'b0, 1'b0, 1'b1);
    check("tp_src_x", xFlr, 232);
    tick();
`ifdef PLAYER_CTRL_TP_EN
    check("tp_dst_x", xFlr, 424);
    check("tp_dst_y", yFlr, 97);
    move(LEFT, 4'b0, 1'b0, 1'b0, 1'b1);
    check("tp_l1_x", xFlr, 392);
    move(RIGHT, 4'b0, 1'b0, 1'b0, 1'b1);
    tick();
    check("tp_disarmed_x", xFlr, 424);
    check("tp_disarmed_y", yFlr, 97);
    move(LEFT, 4'b0, 1'b0, 1'b0, 1'b0);
    move(RIGHT, 4'b0, 1'b0, 1'b0, 1'b1);
    tick();
    check("tp_back_x", xFlr, 232);
    check("tp_back_y", yFlr, 157);
`else
    check("tp_off_x", xFlr, 232);
    check("tp_off_y", yFlr, 157);
    check("tp_off_dead", dead, 0);
`endif

    // 256 deaths saturate the counter at 255
    pulse_restart();
    for (int i = 0; i < 256; i++) begin
      move(RIGHT, 4'b0, 1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 20; k++) begin
        if (!dead) break;
        tick();
      end
    end
    check("sat_deaths", deaths, 255);
    check("sat_x", xFlr, 8);
    check("sat_dead", dead, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
